fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register sitting directly upstream of the main decode/control unit.
- Holds the PC and fetches 32-bit instructions over a req/ack instruction-memory handshake with variable latency.
- Presents one instruction per cycle to decode, with a stall/flush interface and branch/jump redirect.
- Drives id_opcode (instr[31:26]) straight into the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT, 255, maximum cycles an imem request may wait for ack before imem_timeout sets (range 1..65535).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  fetch address; stable while imem_req=1 until ack.
- imem_ack  input  1  rdata valid this cycle; completes the request.
- imem_rdata  input  32  instruction word; sampled only when imem_ack=1.
- stall  input  1  decode hazard; IF/ID must hold its contents.
- redirect  input  1  branch taken or jump; flush and refetch.
- redirect_pc  input  32  target PC; sampled when redirect=1.
- id_valid  output  1  IF/ID holds a real instruction.
- id_instr  output  32  IF/ID instruction; 32'h0 (nop) when id_valid=0.
- id_pc  output  32  address of id_instr.
- id_pc_plus4  output  32  id_pc+4, for branch and jump target calculation.
- id_opcode  output  6  id_instr[31:26]; combinational from the IF/ID register.
- imem_timeout  output  1  sticky error flag.

Behaviour:
Reset (asynchronous, rstn=0):
- pc=RESET_PC, state=REQ.
- id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, id_opcode=0.
- imem_timeout=0, skid empty, wait counter=0.
- imem_req=0 while rstn=0. It rises the first clock edge after rstn deasserts. This releases a mid-flight request; the memory must tolerate that.

Outputs and arithmetic:
- imem_req=1 in states REQ and DRAIN. imem_addr=pc register at all times.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- The two low address bits are not checked.

State REQ:
- ack=1, redirect=0, stall=0: IF/ID<=(rdata, pc, pc+4), id_valid=1, pc<=pc+4. Stay in REQ. Throughput is one instruction per cycle with zero-wait memory.
- ack=1, redirect=0, stall=1: skid<=(rdata, pc), pc<=pc+4, go HOLD. IF/ID is unchanged.
- ack=0, stall=0: id_valid<=0 (bubble).
- ack=0, stall=1: IF/ID holds.
- redirect=1 with ack=1: discard rdata, pc<=redirect_pc, id_valid<=0, stay in REQ.
- redirect=1 with ack=0: tgt<=redirect_pc, id_valid<=0, go DRAIN. The address is held until the outstanding ack.

State HOLD (imem_req=0):
- stall=0: IF/ID<=skid, id_valid=1, go REQ.
- redirect=1 (priority over everything): clear skid, pc<=redirect_pc, id_valid<=0, go REQ.

State DRAIN:
- ack=1: discard rdata, pc<=tgt, go REQ.
- redirect=1 in DRAIN: tgt<=redirect_pc. The latest redirect wins. If ack arrives in the same cycle, pc<=the new redirect_pc.
- id_valid stays 0.

Priority and simultaneous events:
- Priority order: redirect > stall.
- stall=1 and redirect=1 together: flush (id_valid<=0) regardless of stall.

Timeout:
- The wait counter increments each cycle imem_req=1 and ack=0, and clears on ack.
- When the counter reaches TIMEOUT, imem_timeout<=1 and stays set until reset.
- The fetch keeps waiting; the request is not abandoned.

Handshake rule:
- The memory may assert ack only while imem_req=1.
- An ack with imem_req=0 is ignored.

Test Plan:
- Reset release, zero-wait memory returning addr-derived words: id_pc 0,4,8 on consecutive cycles; id_valid=1 from the second edge after release; id_opcode=instr[31:26].
- 3-cycle ack latency: imem_addr held at 0x4 for 3 cycles; id_valid=0 during the wait; then id_instr=mem[0x4].
- stall=1 for 2 cycles while ack returns 0x8: IF/ID keeps 0x4; imem_req=0 in HOLD; after stall drops, id_pc=0x8 next cycle and the next fetch is 0xC.
- redirect to 0x100 during a 2-cycle-latency outstanding fetch of 0x10: imem_addr stays 0x10 until ack; that data is dropped; the next imem_addr is 0x100; no instruction from 0x10 appears with id_valid=1.
- redirect=1 and stall=1 in the same cycle while in HOLD: id_valid=0 next cycle, skid discarded, fetch resumes at redirect_pc.
- TIMEOUT=4, ack withheld for 6 cycles: imem_timeout rises after the 4th wait cycle and stays high after ack. Asserting rstn=0 mid-wait clears all outputs asynchronously and pc returns to RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer
// for stalls, redirect handling, and a sticky imem timeout flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_e;

  localparam logic [16:0] TMO = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        req_q, req_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        ack_v;
  logic [16:0] wait_nxt;

  // An ack is only meaningful while a request is actually on the bus.
  assign ack_v    = imem_ack & req_q;
  assign wait_nxt = {1'b0, wait_cnt_q} + 17'd1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          id_instr_d = 32'h0;
          // With a request still outstanding the address must stay put until ack.
          if (ack_v || !req_q) begin
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = S_DRAIN;
          end
        end else if (ack_v) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end else begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_q + 32'd4;
          end
        end else if (!stall) begin
          id_valid_d = 1'b0;
          id_instr_d = 32'h0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          skid_instr_d = 32'h0;
          skid_pc_d    = 32'h0;
          pc_d         = redirect_pc;
          id_valid_d   = 1'b0;
          id_instr_d   = 32'h0;
          state_d      = S_REQ;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_instr_d = skid_instr_q;
          id_pc_d    = skid_pc_q;
          id_pc4_d   = skid_pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        id_valid_d = 1'b0;
        id_instr_d = 32'h0;
        if (ack_v) begin
          pc_d    = redirect ? redirect_pc : tgt_q;
          state_d = S_REQ;
        end else if (redirect) begin
          tgt_d = redirect_pc;
        end
      end
      default: state_d = S_REQ;
    endcase

    req_d = (state_d != S_HOLD);

    if (ack_v) begin
      wait_cnt_d = 16'h0;
    end else if (req_q) begin
      if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
      if (wait_nxt >= TMO) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      tgt_q        <= 32'h0;
      req_q        <= 1'b0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0;
      id_pc_q      <= 32'h0;
      id_pc4_q     <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      wait_cnt_q   <= 16'h0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      req_q        <= req_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus4  = id_pc4_q;
  assign id_opcode    = id_instr_q[31:26];
  assign imem_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model, scoreboard of consumed
// instructions (id_valid && !stall at negedge), plus directed cycle checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic        imem_timeout;

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_opcode(id_opcode),
    .imem_timeout(imem_timeout)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[7:2], a[25:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lets the monitor consume whatever sits in IF/ID, then resets.
  task automatic reset_dut();
    @(negedge clk);
    #1;
    rstn     = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  // Memory: ack after `lat` wait cycles of a continuous request.
  initial begin
    int wcnt;
    wcnt       = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (!rstn || !imem_req) begin
        wcnt = 0;
      end else if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Scoreboard monitor: an instruction is consumed when valid and not stalled.
  initial begin
    logic [31:0] e, w;
    forever begin
      @(negedge clk);
      if (rstn && id_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc %h expected no instruction", id_pc);
        end else begin
          e = exp_q.pop_front();
          w = mem_word(e);
          chk("sb_pc", id_pc, e);
          chk("sb_instr", id_instr, w);
          chk("sb_opcode", {26'h0, id_opcode}, {26'h0, w[31:26]});
          chk("sb_pc_plus4", id_pc_plus4, e + 32'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h0);
    chk("rst_timeout", {31'h0, imem_timeout}, 32'h0);

    // Zero-wait streaming
    lat = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    rstn = 1'b1;
    tick();
    chk("s1_req_rise", {31'h0, imem_req}, 32'h1);
    chk("s1_valid_e1", {31'h0, id_valid}, 32'h0);
    tick();
    chk("s1_valid_e2", {31'h0, id_valid}, 32'h1);
    chk("s1_pc0", id_pc, 32'h0);
    chk("s1_opcode", {26'h0, id_opcode}, 32'h3F);
    tick();
    chk("s1_pc4", id_pc, 32'h4);
    tick();
    chk("s1_pc8", id_pc, 32'h8);
    reset_dut();

    // Three-cycle latency on 0x4
    lat = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    rstn = 1'b1;
    tick();
    tick();
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_addr_held", imem_addr, 32'h4);
      chk("s2_bubble", {31'h0, id_valid}, 32'h0);
    end
    tick();
    chk("s2_valid", {31'h0, id_valid}, 32'h1);
    chk("s2_instr", id_instr, 32'hF800_0004);
    reset_dut();

    // Stall for two cycles while 0x8 returns
    lat = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    rstn = 1'b1;
    tick();
    tick();
    tick();
    chk("s3_pc4", id_pc, 32'h4);
    stall = 1'b1;
    tick();
    chk("s3_hold_req", {31'h0, imem_req}, 32'h0);
    chk("s3_hold_pc", id_pc, 32'h4);
    tick();
    chk("s3_hold_req2", {31'h0, imem_req}, 32'h0);
    chk("s3_hold_pc2", id_pc, 32'h4);
    stall = 1'b0;
    tick();
    chk("s3_skid_pc", id_pc, 32'h8);
    chk("s3_next_addr", imem_addr, 32'hC);
    chk("s3_req_back", {31'h0, imem_req}, 32'h1);
    tick();
    chk("s3_pcC", id_pc, 32'hC);
    reset_dut();

    // Redirect during an outstanding two-cycle fetch of 0x10
    lat = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h100);
    rstn = 1'b1;
    repeat (5) tick();
    lat         = 2;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("s4_addr_held", imem_addr, 32'h10);
    chk("s4_flush", {31'h0, id_valid}, 32'h0);
    tick();
    chk("s4_addr_held2", imem_addr, 32'h10);
    tick();
    chk("s4_addr_tgt", imem_addr, 32'h100);
    chk("s4_drop", {31'h0, id_valid}, 32'h0);
    lat = 0;
    tick();
    chk("s4_tgt_valid", {31'h0, id_valid}, 32'h1);
    chk("s4_tgt_pc", id_pc, 32'h100);
    reset_dut();

    // Redirect and stall together while in HOLD
    lat = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h200);
    rstn = 1'b1;
    repeat (3) tick();
    stall = 1'b1;
    tick();
    chk("s5_hold_req", {31'h0, imem_req}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("s5_flush", {31'h0, id_valid}, 32'h0);
    chk("s5_addr", imem_addr, 32'h200);
    chk("s5_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk("s5_pc", id_pc, 32'h200);
    reset_dut();

    // Timeout after four wait cycles, then asynchronous reset mid-wait
    lat = 6;
    exp_q.push_back(32'h0);
    rstn = 1'b1;
    repeat (4) tick();
    chk("s6_tmo_low", {31'h0, imem_timeout}, 32'h0);
    tick();
    chk("s6_tmo_set", {31'h0, imem_timeout}, 32'h1);
    repeat (3) tick();
    chk("s6_ack_valid", {31'h0, id_valid}, 32'h1);
    chk("s6_tmo_sticky", {31'h0, imem_timeout}, 32'h1);
    tick();
    chk("s6_tmo_sticky2", {31'h0, imem_timeout}, 32'h1);
    chk("s6_wait_addr", imem_addr, 32'h4);
    #2;
    rstn = 1'b0;
    #1;
    chk("s6_arst_req", {31'h0, imem_req}, 32'h0);
    chk("s6_arst_addr", imem_addr, 32'h0);
    chk("s6_arst_tmo", {31'h0, imem_timeout}, 32'h0);
    chk("s6_arst_valid", {31'h0, id_valid}, 32'h0);
    chk("s6_arst_instr", id_instr, 32'h0);
    chk("s6_arst_pc", id_pc, 32'h0);

    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
